// File: rtl/fetch_unit.sv
// fetch_unit: instruction-fetch stage in front of a combinational inst_mem.
// Owns the PC, registers the fetched instruction with its PC for decode,
// and handles stall, redirect and misaligned-target faulting (sticky HALT).
// Optional performance counters are compiled in with FETCH_PERF_CNT_EN.
module fetch_unit #(
   parameter logic [31:0] RESET_PC    = 32'h0000_0000,
   parameter int unsigned NUM_OF_INST = 1024,
   parameter logic [31:0] NOP_INST    = 32'h0000_0013
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        stall,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_target,
   output logic [31:0] pc_address,
   input  logic [31:0] instruction,
   output logic        if_valid,
   output logic [31:0] if_pc,
   output logic [31:0] if_pc_plus4,
   output logic [31:0] if_instruction,
   output logic        pc_oob,
   output logic        fetch_fault
`ifdef FETCH_PERF_CNT_EN
   ,
   output logic [31:0] perf_fetch_count,
   output logic [31:0] perf_stall_count
`endif
);

   typedef enum logic {RUN, HALT} state_t;

   localparam logic [32:0] OOB_LIMIT = 33'(NUM_OF_INST) << 2;

   state_t      state_q, state_d;
   logic [31:0] pc_q, pc_d;
   logic        if_valid_q, if_valid_d;
   logic [31:0] if_pc_q, if_pc_d;
   logic [31:0] if_instruction_q, if_instruction_d;
   logic        fetch_fault_q, fetch_fault_d;

   logic        redirect_ok;
   logic        redirect_bad;
   logic        advance;
   logic        stall_cycle;

   // FSM state register
   always_ff @(posedge clk) begin
      if (rst) state_q <= RUN;
      else     state_q <= state_d;
   end

   // FSM next state: a misaligned redirect in RUN parks the unit in HALT until reset
   always_comb begin
      state_d = state_q;
      if (state_q == RUN && redirect_valid && redirect_target[1:0] != 2'b00)
         state_d = HALT;
   end

   // FSM outputs: one-hot action strobes for the datapath in RUN, redirect > stall > advance
   always_comb begin
      redirect_ok  = 1'b0;
      redirect_bad = 1'b0;
      advance      = 1'b0;
      stall_cycle  = 1'b0;
      if (state_q == RUN) begin
         if (redirect_valid) begin
            redirect_ok  = (redirect_target[1:0] == 2'b00);
            redirect_bad = (redirect_target[1:0] != 2'b00);
         end else if (stall) begin
            stall_cycle = 1'b1;
         end else begin
            advance = 1'b1;
         end
      end
   end

   // Datapath next values driven by the action strobes
   always_comb begin
      pc_d             = pc_q;
      if_valid_d       = if_valid_q;
      if_pc_d          = if_pc_q;
      if_instruction_d = if_instruction_q;
      fetch_fault_d    = fetch_fault_q;
      if (redirect_ok) begin
         pc_d             = redirect_target;
         if_valid_d       = 1'b0;
         if_instruction_d = NOP_INST;
      end else if (redirect_bad) begin
         fetch_fault_d    = 1'b1;
         if_valid_d       = 1'b0;
         if_instruction_d = NOP_INST;
      end else if (advance) begin
         pc_d             = pc_q + 32'd4;
         if_valid_d       = 1'b1;
         if_pc_d          = pc_q;
         if_instruction_d = instruction;
      end
   end

   // Datapath registers with synchronous reset
   always_ff @(posedge clk) begin
      if (rst) begin
         pc_q             <= RESET_PC;
         if_valid_q       <= 1'b0;
         if_pc_q          <= '0;
         if_instruction_q <= NOP_INST;
         fetch_fault_q    <= 1'b0;
      end else begin
         pc_q             <= pc_d;
         if_valid_q       <= if_valid_d;
         if_pc_q          <= if_pc_d;
         if_instruction_q <= if_instruction_d;
         fetch_fault_q    <= fetch_fault_d;
      end
   end

   assign pc_address     = pc_q;
   assign if_valid       = if_valid_q;
   assign if_pc          = if_pc_q;
   assign if_pc_plus4    = if_pc_q + 32'd4;
   assign if_instruction = if_instruction_q;
   assign fetch_fault    = fetch_fault_q;
   assign pc_oob         = ({1'b0, pc_q} >= OOB_LIMIT);

`ifdef FETCH_PERF_CNT_EN
   logic [31:0] perf_fetch_q, perf_fetch_d;
   logic [31:0] perf_stall_q, perf_stall_d;

   // Performance counter next values; free-running wrap at 2^32
   always_comb begin
      perf_fetch_d = perf_fetch_q + (advance ? 32'd1 : 32'd0);
      perf_stall_d = perf_stall_q + (stall_cycle ? 32'd1 : 32'd0);
   end

   // Performance counter registers
   always_ff @(posedge clk) begin
      if (rst) begin
         perf_fetch_q <= '0;
         perf_stall_q <= '0;
      end else begin
         perf_fetch_q <= perf_fetch_d;
         perf_stall_q <= perf_stall_d;
      end
   end

   assign perf_fetch_count = perf_fetch_q;
   assign perf_stall_count = perf_stall_q;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: scoreboard bench for fetch_unit. Stimulus drives on the
// falling edge and pushes the expected post-edge outputs from a behavioural
// model; a monitor samples just after each rising edge and compares.
// Build with FETCH_PERF_CNT_EN defined to also check the perf counters.
module tb_fetch_unit;

   localparam logic [31:0] NOP = 32'h0000_0013;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        stall = 1'b0;
   logic        redirect_valid = 1'b0;
   logic [31:0] redirect_target = '0;
   logic [31:0] pc_address;
   logic [31:0] instruction;
   logic        if_valid;
   logic [31:0] if_pc;
   logic [31:0] if_pc_plus4;
   logic [31:0] if_instruction;
   logic        pc_oob;
   logic        fetch_fault;
`ifdef FETCH_PERF_CNT_EN
   logic [31:0] perf_fetch_count;
   logic [31:0] perf_stall_count;
`endif

   fetch_unit #(
      .RESET_PC    (32'h0000_0000),
      .NUM_OF_INST (1024),
      .NOP_INST    (NOP)
   ) dut (
      .clk             (clk),
      .rst             (rst),
      .stall           (stall),
      .redirect_valid  (redirect_valid),
      .redirect_target (redirect_target),
      .pc_address      (pc_address),
      .instruction     (instruction),
      .if_valid        (if_valid),
      .if_pc           (if_pc),
      .if_pc_plus4     (if_pc_plus4),
      .if_instruction  (if_instruction),
      .pc_oob          (pc_oob),
      .fetch_fault     (fetch_fault)
`ifdef FETCH_PERF_CNT_EN
      ,
      .perf_fetch_count(perf_fetch_count),
      .perf_stall_count(perf_stall_count)
`endif
   );

   always #5 clk = ~clk;

   // Instruction memory: 1024 words, NOP beyond the end
   logic [31:0] mem [0:1023];
   always_comb begin
      if (pc_address < 32'd4096) instruction = mem[pc_address[11:2]];
      else                       instruction = NOP;
   end

   typedef struct {
      logic [31:0] pc;
      logic        oob;
      logic        valid;
      logic [31:0] ipc;
      logic [31:0] ipc4;
      logic [31:0] instr;
      logic        fault;
      logic [31:0] fcnt;
      logic [31:0] scnt;
   } exp_t;

   exp_t exp_q[$];
   int unsigned n_vec = 0;
   int unsigned n_err = 0;

   // Reference model state
   longint unsigned m_pc;
   bit              m_halt;
   bit              m_fault;
   bit              m_valid;
   longint unsigned m_ipc;
   logic [31:0]     m_instr;
   longint unsigned m_fcnt;
   longint unsigned m_scnt;

   function automatic logic [31:0] mem_word(longint unsigned a);
      if (a < 4096) return mem[a / 4];
      return NOP;
   endfunction

   // Apply one cycle of inputs, advance the model, and record what must follow the edge
   task automatic cycle(input bit r, input bit s, input bit rv, input logic [31:0] tgt);
      exp_t e;
      @(negedge clk);
      rst = r; stall = s; redirect_valid = rv; redirect_target = tgt;
      if (r) begin
         m_pc = 0; m_halt = 0; m_fault = 0; m_valid = 0; m_ipc = 0;
         m_instr = NOP; m_fcnt = 0; m_scnt = 0;
      end else if (m_halt) begin
         m_valid = 0;
      end else if (rv) begin
         m_valid = 0;
         m_instr = NOP;
         if (tgt % 4 == 0) m_pc = tgt;
         else begin m_halt = 1; m_fault = 1; end
      end else if (s) begin
         m_scnt = (m_scnt + 1) % 64'h1_0000_0000;
      end else begin
         m_instr = mem_word(m_pc);
         m_ipc   = m_pc;
         m_valid = 1;
         m_pc    = (m_pc + 4) % 64'h1_0000_0000;
         m_fcnt  = (m_fcnt + 1) % 64'h1_0000_0000;
      end
      e.pc    = 32'(m_pc);
      e.oob   = (m_pc >= 4096);
      e.valid = m_valid;
      e.ipc   = 32'(m_ipc);
      e.ipc4  = 32'((m_ipc + 4) % 64'h1_0000_0000);
      e.instr = m_instr;
      e.fault = m_fault;
      e.fcnt  = 32'(m_fcnt);
      e.scnt  = 32'(m_scnt);
      exp_q.push_back(e);
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      n_vec++;
      if (act !== req) begin
         n_err++;
         $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, req, $time);
      end
   endtask

   // Monitor: compare DUT outputs against the oldest expectation after each edge
   initial begin
      exp_t e;
      forever begin
         @(posedge clk);
         #1;
         if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            chk("pc_address",     pc_address,          e.pc);
            chk("pc_oob",         32'(pc_oob),         32'(e.oob));
            chk("if_valid",       32'(if_valid),       32'(e.valid));
            chk("if_pc",          if_pc,               e.ipc);
            chk("if_pc_plus4",    if_pc_plus4,         e.ipc4);
            chk("if_instruction", if_instruction,      e.instr);
            chk("fetch_fault",    32'(fetch_fault),    32'(e.fault));
`ifdef FETCH_PERF_CNT_EN
            chk("perf_fetch",     perf_fetch_count,    e.fcnt);
            chk("perf_stall",     perf_stall_count,    e.scnt);
`endif
         end
      end
   end

   initial begin
      logic [31:0] tgt;
      int unsigned pick;
      for (int i = 0; i < 1024; i++) mem[i] = $urandom();
      mem[0]    = 32'h0010_0033;
      mem[1]    = 32'h0020_0113;
      mem[2]    = 32'h0030_2193;
      mem[1023] = 32'h0040_4233;

      // Reset, sequential fetch, stall, release
      cycle(1, 0, 0, '0);
      cycle(1, 0, 0, '0);
      cycle(0, 0, 0, '0);
      cycle(0, 0, 0, '0);
      cycle(0, 1, 0, '0);
      cycle(0, 1, 0, '0);
      cycle(0, 0, 0, '0);
      // Redirect together with stall, then run off the end of memory
      cycle(0, 1, 1, 32'h0000_0FFC);
      cycle(0, 0, 0, '0);
      cycle(0, 0, 0, '0);
      cycle(0, 0, 0, '0);
      // Back-to-back redirects: last wins
      cycle(0, 0, 1, 32'h0000_0040);
      cycle(0, 0, 1, 32'h0000_0010);
      cycle(0, 0, 0, '0);
      // PC wrap at 2^32
      cycle(0, 0, 1, 32'hFFFF_FFFC);
      cycle(0, 0, 0, '0);
      cycle(0, 0, 0, '0);
      // Misaligned redirect, then HALT ignores redirect and stall
      cycle(0, 0, 1, 32'h0000_0006);
      cycle(0, 1, 1, 32'h0000_0000);
      cycle(0, 1, 0, '0);
      cycle(0, 0, 0, '0);
      cycle(1, 0, 0, '0);
      cycle(0, 0, 0, '0);

      // Randomized traffic
      for (int n = 0; n < 2000; n++) begin
         pick = $urandom_range(0, 99);
         case ($urandom_range(0, 3))
            0:       tgt = {20'h0, 10'($urandom_range(1000, 1023)), 2'b00};
            1:       tgt = 32'h0000_1000 + {$urandom_range(0, 15), 2'b00};
            default: tgt = {20'h0, 10'($urandom_range(0, 1023)), 2'b00};
         endcase
         if (pick < 3)       cycle(1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), tgt);
         else if (pick < 5)  cycle(0, 1'($urandom_range(0, 1)), 1, tgt | 32'($urandom_range(1, 3)));
         else if (pick < 17) cycle(0, 1'($urandom_range(0, 1)), 1, tgt);
         else if (pick < 40) cycle(0, 1, 0, $urandom());
         else                cycle(0, 0, 0, $urandom());
      end
      cycle(0, 0, 0, '0);

      repeat (2) @(posedge clk);
      #2;
      if (exp_q.size() != 0) begin
         n_vec++;
         n_err++;
         $display("FAIL drain: got %0d pending, expected 0", exp_q.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction-fetch stage that sits directly upstream of `inst_mem`.
- Owns the program counter and drives `pc_address` into `inst_mem`, which is combinational.
- Registers the returned instruction, together with its PC, into a fetch output register consumed by decode.
- Handles stall, branch/jump redirect and misaligned-target faulting.

Parameters:
- RESET_PC, 32'h00000000, PC loaded on reset.
- NUM_OF_INST, 1024, instruction count of the downstream `inst_mem`; used only for `pc_oob`.
- NOP_INST, 32'h00000013, bubble value (ADDI x0,x0,0) placed in `if_instruction` when not valid.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- stall  input  1  hold PC and fetch register this cycle.
- redirect_valid  input  1  load PC from `redirect_target`; squashes the in-flight fetch.
- redirect_target  input  32  new PC (branch/jump target).
- pc_address  output  32  current PC, driven to `inst_mem.pc_address`; equals the PC register (no logic after the register).
- instruction  input  32  from `inst_mem.instruction`.
- if_valid  output  1  `if_instruction`/`if_pc` hold a real fetched instruction.
- if_pc  output  32  PC of `if_instruction`.
- if_pc_plus4  output  32  `if_pc + 4` (mod 2^32).
- if_instruction  output  32  registered instruction.
- pc_oob  output  1  combinational; `pc_address >= NUM_OF_INST*4`.
- fetch_fault  output  1  sticky misaligned-redirect fault.

Behaviour:
- FSM states: RUN, HALT.
- Reset (rst=1 at a rising edge), overriding everything including mid-redirect or mid-stall:
  - PC=RESET_PC, state=RUN.
  - if_valid=0, if_pc=0, if_pc_plus4=4, if_instruction=NOP_INST, fetch_fault=0.
- RUN priority, highest first: redirect_valid, then stall, then normal advance.
- Normal advance (no redirect, no stall), at the clock edge:
  - if_instruction<=instruction, if_pc<=PC, if_valid<=1, PC<=PC+4.
  - Fetch latency is 1 cycle: the instruction at address A appears on `if_instruction` the cycle after PC=A.
- Stall without redirect: PC and all if_* registers hold; if_valid keeps its value.
- Redirect with redirect_target[1:0]==0, regardless of stall:
  - PC<=redirect_target.
  - if_valid<=0, if_instruction<=NOP_INST; if_pc/if_pc_plus4 hold.
  - The following cycle fetches from the target.
- Redirect with redirect_target[1:0]!=0:
  - state<=HALT, fetch_fault<=1, PC holds.
  - if_valid<=0, if_instruction<=NOP_INST.
- HALT: all registers hold and if_valid=0; stall and redirect are ignored. Only rst exits, to RUN.
- PC wrap: 32'hFFFFFFFC+4 -> 32'h00000000, with no flag.
- pc_oob does not stop fetch; `inst_mem` supplies NOP for out-of-range addresses and this block registers it normally.
- Back-to-back redirects: each one squashes and reloads; the last one wins.
- Stall is never asserted by this block; there is no internal buffering.

Optional Feature:
- Macro FETCH_PERF_CNT_EN.
- Defined:
  - Adds outputs `perf_fetch_count[31:0]` and `perf_stall_count[31:0]`, both reset to 0 and wrapping at 2^32.
  - `perf_fetch_count` increments on each normal advance.
  - `perf_stall_count` increments on each RUN cycle with stall=1 and redirect_valid=0.
  - Neither counter changes in HALT.
- Undefined: both ports and counters are absent; all other behaviour is identical.

Test Plan:
- Reset/sequential fetch: preload inst_mem[0..2]=00100033, 00200113, 00302193; release rst.
  - Cycle 0: pc_address=0, if_valid=0, if_instruction=00000013.
  - Next 3 cycles: if_instruction=00100033, 00200113, 00302193 with if_pc=0, 4, 8, and pc_address=4, 8, C.
- Stall: assert stall for 2 cycles while pc_address=8.
  - pc_address stays 8; if_pc=4 and if_instruction=00200113 hold.
  - After release, next output is 00302193 at if_pc=8.
- Redirect, simultaneous with stall: redirect_valid=1, target=0xFFC, stall=1 while pc_address=8.
  - Next cycle: pc_address=FFC, if_valid=0, if_instruction=00000013.
  - Following cycle: if_instruction=inst_mem[1023]=00404233, if_pc=FFC, if_pc_plus4=1000.
- Out-of-range: continue from 0xFFC.
  - pc_address=1000 gives pc_oob=1; next cycle if_instruction=00000013 with if_valid=1.
- Misaligned redirect: target=0x00000006.
  - fetch_fault=1, if_valid=0, pc_address frozen.
  - Redirect to 0x0 and stall are ignored.
  - rst clears to pc_address=0, fetch_fault=0.
- FETCH_PERF_CNT_EN: after 3 advances and 2 stall cycles, perf_fetch_count=3 and perf_stall_count=2; rst zeroes both.
